// File: rtl/led_btn_ip.sv
// AXI4-Lite LED/button peripheral: LED and scratch registers, latched button
// capture and a maskable level interrupt on each new press.
module led_btn_ip #(
    parameter int LED_WIDTH            = 4,
    parameter int BTN_WIDTH            = 4,
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 5
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    output logic [LED_WIDTH-1:0]              led,
    input  logic [BTN_WIDTH-1:0]              btn,
    output logic                              irq,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready
);
    localparam int NB = C_S00_AXI_DATA_WIDTH / 8;

    logic                 awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [31:0]          rdata_q, rdata_d;
    logic [2:0]           ar_idx_q;
    logic [31:0]          led_q, led_d, scratch_q, scratch_d;
    logic                 en_q, en_d, clr_q, clr_d, pend_q, pend_d;
    logic [BTN_WIDTH-1:0] btn_prev_q, btn_lat_q, btn_lat_d, rise;
    logic                 wr_accept;
    logic [2:0]           wr_idx;
    logic                 unused_ok;

    // A write is taken only when both channels are valid and no response is outstanding.
    assign wr_accept = s00_axi_awvalid & s00_axi_wvalid & ~awready_q & ~wready_q & ~bvalid_q;
    assign wr_idx    = s00_axi_awaddr[4:2];
    assign rise      = btn & ~btn_prev_q;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign led_d[8*gi +: 8] = (wr_accept && wr_idx == 3'd0 && s00_axi_wstrb[gi])
                                      ? s00_axi_wdata[8*gi +: 8] : led_q[8*gi +: 8];
            assign scratch_d[8*gi +: 8] = (wr_accept && wr_idx == 3'd2 && s00_axi_wstrb[gi])
                                      ? s00_axi_wdata[8*gi +: 8] : scratch_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        en_d      = en_q;
        clr_d     = clr_q;
        btn_lat_d = btn_lat_q;
        pend_d    = pend_q;
        if (wr_accept && wr_idx == 3'd3 && s00_axi_wstrb[0]) begin
            en_d  = s00_axi_wdata[0];
            clr_d = s00_axi_wdata[1];
        end
        // Clear dominates; otherwise only the first press after a clear is captured.
        if (clr_q) begin
            pend_d = 1'b0;
        end else if ((|rise) && !pend_q) begin
            btn_lat_d = btn;
            if (en_q) begin
                pend_d = 1'b1;
            end
        end
    end

    always_comb begin
        rdata_d = 32'd0;
        case (ar_idx_q)
            3'd0:    rdata_d = led_q;
            3'd1:    rdata_d = {{(32-BTN_WIDTH){1'b0}}, btn_lat_q};
            3'd2:    rdata_d = scratch_q;
            3'd3:    rdata_d = {29'd0, pend_q, clr_q, en_q};
            default: rdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'd0;
            ar_idx_q   <= 3'd0;
            led_q      <= 32'd0;
            scratch_q  <= 32'd0;
            en_q       <= 1'b0;
            clr_q      <= 1'b0;
            pend_q     <= 1'b0;
            btn_prev_q <= '0;
            btn_lat_q  <= '0;
        end else begin
            awready_q  <= wr_accept;
            wready_q   <= wr_accept;
            if (awready_q) begin
                bvalid_q <= 1'b1;
            end else if (bvalid_q && s00_axi_bready) begin
                bvalid_q <= 1'b0;
            end
            arready_q  <= s00_axi_arvalid & ~arready_q & ~rvalid_q;
            if (s00_axi_arvalid && !arready_q && !rvalid_q) begin
                ar_idx_q <= s00_axi_araddr[4:2];
            end
            if (arready_q) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
            end else if (rvalid_q && s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end
            led_q      <= led_d;
            scratch_q  <= scratch_d;
            en_q       <= en_d;
            clr_q      <= clr_d;
            pend_q     <= pend_d;
            btn_prev_q <= btn;
            btn_lat_q  <= btn_lat_d;
        end
    end

    assign led             = led_q[LED_WIDTH-1:0];
    assign irq             = pend_q & en_q;
    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;

    // Protection bits and sub-word address bits carry no meaning here.
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
endmodule

// File: tb/tb_led_btn_ip.sv
// Directed bench for led_btn_ip: register access, AXI handshakes, button capture and irq.
module tb_led_btn_ip;
    logic        clk = 1'b0;
    logic        srst;
    logic [3:0]  led;
    logic [3:0]  btn;
    logic        irq;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] rd;

    led_btn_ip dut (
        .s00_axi_aclk(clk), .s00_axi_areset(srst), .led(led), .btn(btn), .irq(irq),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed=timeout expected=handshake", tag);
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit chk_hs);
        bit seen = 0;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (awready) begin seen = 1; break; end
        end
        if (!seen) begin
            timeout("awready");
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        if (chk_hs) check("wready_with_awready", {31'd0, wready}, 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        if (chk_hs) begin
            check("awready_one_cycle", {31'd0, awready}, 32'd0);
            check("wready_one_cycle", {31'd0, wready}, 32'd0);
            check("bvalid_rise", {31'd0, bvalid}, 32'd1);
            @(negedge clk);
            check("bvalid_hold", {31'd0, bvalid}, 32'd1);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        if (chk_hs) check("bvalid_clear", {31'd0, bvalid}, 32'd0);
        $display("write addr=0x%02h data=0x%08h strb=%b", addr, data, strb);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
        bit seen = 0;
        int n = 0;
        data = 32'hxxxx_xxxx;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (arready) begin seen = 1; break; end
        end
        if (!seen) begin
            timeout("arready");
            arvalid = 1'b0;
            return;
        end
        @(negedge clk);
        arvalid = 1'b0;
        while (!rvalid && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) begin
            timeout("rvalid");
            return;
        end
        data = rdata;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        $display("read  addr=0x%02h data=0x%08h", addr, data);
    endtask

    task automatic press(input logic [3:0] val);
        @(negedge clk); btn = val;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        srst = 1'b1; btn = 4'd0;
        awaddr = '0; awprot = '0; awvalid = 0; wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
        araddr = '0; arprot = '0; arvalid = 0; rready = 0;
        repeat (3) @(negedge clk);
        srst = 1'b0;
        check("rst_led", {28'd0, led}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
        check("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
        axi_read(5'h00, rd); check("rst_rd_led", rd, 32'h0);
        axi_read(5'h04, rd); check("rst_rd_btn", rd, 32'h0);
        axi_read(5'h0C, rd); check("rst_rd_int", rd, 32'h0);

        axi_write(5'h00, 32'h0000_000A, 4'hF, 1'b1);
        check("led_A", {28'd0, led}, 32'hA);
        axi_read(5'h00, rd); check("rd_led_A", rd, 32'h0000_000A);

        axi_write(5'h0C, 32'h1, 4'hF, 1'b0);
        press(4'b1010);
        check("irq_press1", {31'd0, irq}, 32'd1);
        btn = 4'b0000;
        axi_read(5'h04, rd); check("btn_A", rd, 32'h0000_000A);
        axi_read(5'h0C, rd); check("int_en_pend", rd, 32'h5);

        axi_write(5'h0C, 32'h0, 4'hF, 1'b0);
        check("irq_masked", {31'd0, irq}, 32'd0);
        axi_read(5'h0C, rd); check("pend_kept", rd, 32'h4);
        axi_write(5'h0C, 32'h2, 4'hF, 1'b0);
        axi_read(5'h0C, rd); check("pend_cleared", rd, 32'h2);
        axi_write(5'h0C, 32'h0, 4'hF, 1'b0);
        axi_read(5'h04, rd);
        axi_write(5'h00, rd, 4'hF, 1'b0);
        check("led_from_btn", {28'd0, led}, 32'hA);
        axi_write(5'h0C, 32'h1, 4'hF, 1'b0);
        check("irq_stays_0", {31'd0, irq}, 32'd0);

        press(4'b0101);
        check("irq_press2", {31'd0, irq}, 32'd1);
        btn = 4'b0000;
        axi_read(5'h04, rd); check("btn_5", rd, 32'h5);
        press(4'b1100);
        btn = 4'b0000;
        axi_read(5'h04, rd); check("btn_held_pend", rd, 32'h5);
        axi_write(5'h0C, 32'h0, 4'hF, 1'b0);
        axi_write(5'h0C, 32'h2, 4'hF, 1'b0);
        axi_write(5'h0C, 32'h0, 4'hF, 1'b0);
        axi_write(5'h00, 32'h5, 4'hF, 1'b0);
        check("led_5", {28'd0, led}, 32'h5);
        axi_write(5'h0C, 32'h1, 4'hF, 1'b0);
        axi_read(5'h0C, rd); check("int_en_only", rd, 32'h1);

        axi_write(5'h0C, 32'h0, 4'hF, 1'b0);
        press(4'b0011);
        btn = 4'b0000;
        check("irq_en0", {31'd0, irq}, 32'd0);
        axi_read(5'h04, rd); check("btn_3_en0", rd, 32'h3);
        axi_read(5'h0C, rd); check("pend_en0", rd, 32'h0);
        axi_write(5'h04, 32'hFF, 4'hF, 1'b0);
        axi_read(5'h04, rd); check("btn_ro", rd, 32'h3);
        axi_write(5'h14, 32'h1234_5678, 4'hF, 1'b0);
        axi_read(5'h14, rd); check("hole_0x14", rd, 32'h0);

        axi_write(5'h08, 32'hDEAD_BEEF, 4'hF, 1'b0);
        axi_read(5'h08, rd); check("scratch", rd, 32'hDEAD_BEEF);
        axi_write(5'h08, 32'h1122_3344, 4'b0101, 1'b0);
        axi_read(5'h08, rd); check("scratch_strb", rd, 32'hDE22_BE44);
        axi_write(5'h00, 32'h1234_5675, 4'hF, 1'b0);
        axi_read(5'h00, rd); check("led_upper", rd, 32'h1234_5675);
        check("led_low", {28'd0, led}, 32'h5);

        axi_write(5'h0C, 32'h3, 4'hF, 1'b0);
        press(4'b1000);
        btn = 4'b0000;
        check("irq_clr_wins", {31'd0, irq}, 32'd0);
        axi_read(5'h0C, rd); check("int_clr_wins", rd, 32'h3);
        axi_write(5'h0C, 32'h1, 4'hF, 1'b0);
        check("irq_after_clr", {31'd0, irq}, 32'd0);

        @(negedge clk);
        awaddr = 5'h00; wdata = 32'hF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        begin
            bit seen = 0;
            for (int n = 0; n < 16; n++) begin
                @(negedge clk);
                if (awready) begin seen = 1; break; end
            end
            if (!seen) timeout("awready_midrst");
        end
        srst = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        srst = 1'b0;
        check("midrst_ready", {30'd0, awready, wready}, 32'd0);
        check("midrst_bvalid", {31'd0, bvalid}, 32'd0);
        check("midrst_led", {28'd0, led}, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
